// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester handshakes, response bus and ALU input/output bus around the arbiter.
interface alu_req_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_op;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [1:0]          req_eq;
    logic [5:0]          req_ltgt;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_cmp;
    logic                rsp_err;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   alu_register;
    logic                alu_eq;
    logic [2:0]          alu_ltgt;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_compres;

    modport master (
        output req_valid, req_op, req_a, req_b, req_eq, req_ltgt, rsp_ready, alu_out, alu_compres,
        input  req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_err,
               alu_op, alu_res, alu_register, alu_eq, alu_ltgt
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_eq, req_ltgt, rsp_ready, alu_out, alu_compres,
        output req_ready, rsp_valid, rsp_result, rsp_cmp, rsp_err,
               alu_op, alu_res, alu_register, alu_eq, alu_ltgt
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters, one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention (no round-robin pointer).
module alu_req_arbiter #(
    parameter int DATA_W        = 16,
    parameter int OP_W          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    alu_req_arbiter_if.slave  bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              eq_q;
    logic [2:0]        ltgt_q;
    logic              grant;
    logic [3:0]        cnt;
    logic              sel, accept, supported, settled, exec;
    logic [OP_W-1:0]   sel_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign sel = ~bus.req_valid[0];
`else
    logic rr_ptr;
    assign sel = &bus.req_valid ? rr_ptr : bus.req_valid[1];
`endif

    assign sel_op    = sel ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0];
    assign supported = sel_op == OP_W'(0) || sel_op == OP_W'(4) || sel_op == OP_W'(5);
    assign accept    = state == IDLE && |bus.req_valid;
    assign settled   = cnt == 4'(SETTLE_CYCLES - 1);
    assign exec      = state == EXEC;

    assign bus.req_ready    = accept && reset_n ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid    = state == RESP ? (grant ? 2'b10 : 2'b01) : 2'b00;
    // The ALU bus is only driven while an operation settles; otherwise it idles at no-op/zero.
    assign bus.alu_op       = exec ? op_q : {OP_W{1'b1}};
    assign bus.alu_res      = exec ? a_q : '0;
    assign bus.alu_register = exec ? b_q : '0;
    assign bus.alu_eq       = exec & eq_q;
    assign bus.alu_ltgt     = exec ? ltgt_q : 3'b000;
    assign busy             = state != IDLE;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (accept ? (supported ? EXEC : RESP) : IDLE) :
                    state == EXEC ? (settled ? RESP : EXEC) :
                    state == RESP ? (bus.rsp_ready[grant] ? IDLE : RESP) : IDLE;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            eq_q           <= 1'b0;
            ltgt_q         <= 3'b000;
            grant          <= 1'b0;
            cnt            <= 4'd0;
            bus.rsp_result <= '0;
            bus.rsp_cmp    <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= sel_op;
                a_q    <= sel ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
                b_q    <= sel ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
                eq_q   <= bus.req_eq[sel];
                ltgt_q <= sel ? bus.req_ltgt[5:3] : bus.req_ltgt[2:0];
                grant  <= sel;
                cnt    <= 4'd0;
            end
            if (accept && !supported) begin
                bus.rsp_result <= '0;
                bus.rsp_cmp    <= 1'b0;
                bus.rsp_err    <= 1'b1;
            end
            if (exec) cnt <= cnt + 4'd1;
            if (exec && settled) begin
                bus.rsp_result <= bus.alu_out;
                bus.rsp_cmp    <= bus.alu_compres;
                bus.rsp_err    <= 1'b0;
            end
        end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)                                  rr_ptr <= 1'b0;
        else if (state == RESP && bus.rsp_ready[grant]) rr_ptr <= ~grant;
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed plus randomized transactions checked against a transaction-level model.
module tb_alu_req_arbiter;
    localparam int DW = 16;
    localparam int OW = 4;
    localparam int S  = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_rr   = 1'b0;

    logic [3:0]  op_t[2];
    logic [15:0] a_t[2];
    logic [15:0] b_t[2];
    logic        eq_t[2];
    logic [2:0]  lt_t[2];

    alu_req_arbiter_if #(.DATA_W(DW), .OP_W(OW)) ifc ();

    alu_req_arbiter #(.DATA_W(DW), .OP_W(OW), .SETTLE_CYCLES(S)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(ifc),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: {compres, out}; anything but add/sub, compare and parity yields zero.
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic eq, input logic [2:0] lt);
        case (op)
            4'd0:    return {1'b0, eq ? a + b : a - b};
            4'd4:    return {(lt[0] && a > b) || (lt[1] && a < b) || (eq && a == b), a};
            4'd5:    return {1'b0, 15'd0, ^a};
            default: return 17'd0;
        endcase
    endfunction

    assign {ifc.alu_compres, ifc.alu_out} = alu_f(ifc.alu_op, ifc.alu_res, ifc.alu_register, ifc.alu_eq, ifc.alu_ltgt);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic eq, input logic [2:0] lt);
        op_t[i] = op;
        a_t[i]  = a;
        b_t[i]  = b;
        eq_t[i] = eq;
        lt_t[i] = lt;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < 2; i++) begin
            ifc.req_op[i*4 +: 4]   = op_t[i];
            ifc.req_a[i*16 +: 16]  = a_t[i];
            ifc.req_b[i*16 +: 16]  = b_t[i];
            ifc.req_eq[i]          = eq_t[i];
            ifc.req_ltgt[i*3 +: 3] = lt_t[i];
        end
    endtask

    task automatic load_random(input int i);
        int          o;
        logic [3:0]  op;
        logic [15:0] a;
        o  = $urandom_range(0, 7);
        op = o == 0 ? 4'd0 : o == 1 ? 4'd4 : o == 2 ? 4'd5 : o == 3 ? 4'd4 : 4'($urandom);
        a  = 16'($urandom);
        load(i, op, a, $urandom_range(0, 3) == 0 ? a : 16'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic transact(input logic [1:0] mask, input int hold);
        int          g;
        int          lat;
        logic [16:0] r;
        logic        bad;
        logic [1:0]  oh;
        @(negedge clock);
        drive_fields();
        ifc.req_valid = mask;
        #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        g = mask[0] ? 0 : 1;
`else
        g = mask == 2'b11 ? int'(exp_rr) : (mask[1] ? 1 : 0);
`endif
        oh  = g[0] ? 2'b10 : 2'b01;
        bad = !(op_t[g] inside {4'd0, 4'd4, 4'd5});
        r   = alu_f(op_t[g], a_t[g], b_t[g], eq_t[g], lt_t[g]);
        check("req_ready", 32'(ifc.req_ready), 32'(oh));
        @(posedge clock);
        #1;
        ifc.req_valid = 2'b00;
        check("exec_alu_op", 32'(ifc.alu_op), bad ? 32'hF : 32'(op_t[g]));
        lat = 0;
        while (ifc.rsp_valid == 2'b00 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", 32'(lat), bad ? 32'd0 : 32'(S));
        check("rsp_valid", 32'(ifc.rsp_valid), 32'(oh));
        check("rsp_result", 32'(ifc.rsp_result), 32'(r[15:0]));
        check("rsp_cmp", 32'(ifc.rsp_cmp), 32'(r[16]));
        check("rsp_err", 32'(ifc.rsp_err), 32'(bad));
        check("resp_alu_op", 32'(ifc.alu_op), 32'hF);
        ifc.rsp_ready = ~oh;
        ifc.req_valid = 2'b11;
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        check("hold_valid", 32'(ifc.rsp_valid), 32'(oh));
        check("hold_ready", 32'(ifc.req_ready), 32'd0);
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = oh;
        @(posedge clock);
        #1;
        ifc.rsp_ready = 2'b00;
        check("done_valid", 32'(ifc.rsp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        exp_rr = ~g[0];
    endtask

    initial begin
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) load(i, 4'd0, 16'd0, 16'd0, 1'b0, 3'd0);
        drive_fields();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_op", 32'(ifc.alu_op), 32'hF);
        check("rst_alu_res", 32'(ifc.alu_res), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        check("rst_rsp", {13'd0, ifc.rsp_err, ifc.rsp_cmp, 1'b0, ifc.rsp_result}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        load(0, 4'd0, 16'd3, 16'd5, 1'b1, 3'd0);
        transact(2'b01, 0);
        load(1, 4'd0, 16'd10, 16'd3, 1'b0, 3'd0);
        transact(2'b10, 1);
        load(1, 4'd5, 16'h0007, 16'd0, 1'b0, 3'd0);
        transact(2'b10, 0);
        load(0, 4'd4, 16'd5, 16'd3, 1'b1, 3'd1);
        transact(2'b01, 2);
        load(0, 4'd4, 16'd5, 16'd3, 1'b1, 3'd0);
        transact(2'b01, 0);
        for (int k = 0; k < 4; k++) begin
            load_random(0);
            load_random(1);
            transact(2'b11, 0);
        end
        load(0, 4'h3, 16'd9, 16'd9, 1'b1, 3'd7);
        load(1, 4'd0, 16'd1, 16'd1, 1'b1, 3'd0);
        transact(2'b01, 10);

        // Reset during EXEC: the operation must vanish without a response.
        load(0, 4'd0, 16'd1, 16'd2, 1'b1, 3'd0);
        @(negedge clock);
        drive_fields();
        ifc.req_valid = 2'b01;
        @(posedge clock);
        #1;
        ifc.req_valid = 2'b00;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_alu_op", 32'(ifc.alu_op), 32'hF);
        check("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_rr  = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("post_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        load(1, 4'd0, 16'd100, 16'd1, 1'b0, 3'd0);
        transact(2'b11, 0);

        for (int k = 0; k < 200; k++) begin
            load_random(0);
            load_random(1);
            transact(2'($urandom_range(1, 3)), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
